// File: rtl/uart_tx_frame_ctrl_if.sv
// Handshake and frame-select bundle between the UART TX
// byte source and the frame control / serializer stage.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            Mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  Mux_sel,
        input  ser_data,
        input  par_bit,
        input  busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output Mux_sel,
        output ser_data,
        output par_bit,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, parity, stop.
// Optional second stop bit enabled by UART_TX_TWO_STOP_EN.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_frame_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } state_t;

    state_t                st;
    state_t                nxt;
    logic [DATA_WIDTH-1:0] sh;
    logic [CNT_W-1:0]      cnt;
    logic                  pen_q;
    logic                  par_q;
    logic                  accept;
    logic                  last;

    assign last = (cnt == CNT_W'(DATA_WIDTH - 1));

`ifdef UART_TX_TWO_STOP_EN
    assign accept = bus.Data_Valid &&
                    ((st == IDLE) || (st == STOP2));
`else
    assign accept = bus.Data_Valid &&
                    ((st == IDLE) || (st == STOP));
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Next-state sequencing through the frame fields
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:   nxt = accept ? START : IDLE;
            START:  nxt = DATA;
            DATA: begin
                if (last) begin
                    nxt = pen_q ? PARITY : STOP;
                end
            end
            PARITY: nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:   nxt = STOP2;
            STOP2:  nxt = accept ? START : IDLE;
`else
            STOP:   nxt = accept ? START : IDLE;
            STOP2:  nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Byte latch, shifter, bit counter and parity capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh    <= '0;
            cnt   <= '0;
            pen_q <= 1'b0;
            par_q <= 1'b0;
        end else if (accept) begin
            sh    <= bus.P_DATA;
            cnt   <= '0;
            pen_q <= bus.PAR_EN;
            par_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
        end else if (st == DATA) begin
            sh  <= sh >> 1;
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Field select and busy decoded from the state register
    always_comb begin
        bus.Mux_sel = 2'b11;
        bus.busy    = 1'b0;
        unique case (st)
            START: begin
                bus.Mux_sel = 2'b00;
                bus.busy    = 1'b1;
            end
            DATA: begin
                bus.Mux_sel = 2'b01;
                bus.busy    = 1'b1;
            end
            PARITY: begin
                bus.Mux_sel = 2'b10;
                bus.busy    = 1'b1;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                bus.Mux_sel = 2'b11;
                bus.busy    = 1'b1;
            end
`endif
            default: begin
                bus.Mux_sel = 2'b11;
                bus.busy    = 1'b0;
            end
        endcase
    end

    assign bus.ser_data = sh[0];
    assign bus.par_bit  = par_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl (8-bit data).
// Covers idle, parity modes, chaining, ignored requests, reset.
module tb_uart_tx_frame_ctrl;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Sends one frame; leaves the bench in the last stop cycle.
    // hold keeps Data_Valid high; inj puts a 0xFF request
    // after the given data bit.
    task automatic frame(input logic [7:0] d,
                         input logic pen,
                         input logic ptyp,
                         input logic exp_par,
                         input logic hold,
                         input int inj,
                         input string tg);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        tick();
        if (!hold) bus.Data_Valid = 1'b0;
        chk({tg, "_start_sel"}, 32'(bus.Mux_sel), 32'h0);
        chk({tg, "_start_busy"}, 32'(bus.busy), 32'h1);
        chk({tg, "_par"}, 32'(bus.par_bit), 32'(exp_par));
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!hold) begin
                bus.Data_Valid = 1'b0;
                bus.P_DATA     = d;
            end
            chk($sformatf("%s_d%0d_sel", tg, k),
                32'(bus.Mux_sel), 32'h1);
            chk($sformatf("%s_d%0d_bit", tg, k),
                32'(bus.ser_data), 32'(d[k]));
            chk($sformatf("%s_d%0d_busy", tg, k),
                32'(bus.busy), 32'h1);
            if (k == inj) begin
                bus.Data_Valid = 1'b1;
                bus.P_DATA     = 8'hFF;
            end
        end
        if (pen) begin
            tick();
            chk({tg, "_p_sel"}, 32'(bus.Mux_sel), 32'h2);
            chk({tg, "_p_bit"}, 32'(bus.par_bit),
                32'(exp_par));
            chk({tg, "_p_busy"}, 32'(bus.busy), 32'h1);
        end
        tick();
        chk({tg, "_stop_sel"}, 32'(bus.Mux_sel), 32'h3);
`ifdef UART_TX_TWO_STOP_EN
        chk({tg, "_stop_busy"}, 32'(bus.busy), 32'h1);
        tick();
        chk({tg, "_stop2_sel"}, 32'(bus.Mux_sel), 32'h3);
        chk({tg, "_stop2_busy"}, 32'(bus.busy), 32'h0);
`else
        chk({tg, "_stop_busy"}, 32'(bus.busy), 32'h0);
`endif
    endtask

    task automatic idle(input int n, input string tg);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_idle%0d_sel", tg, i),
                32'(bus.Mux_sel), 32'h3);
            chk($sformatf("%s_idle%0d_busy", tg, i),
                32'(bus.busy), 32'h0);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        RST            = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        tick();
        tick();
        chk("rst_sel", 32'(bus.Mux_sel), 32'h3);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ser", 32'(bus.ser_data), 32'h0);
        chk("rst_par", 32'(bus.par_bit), 32'h0);
        #3;
        RST = 1'b1;
        idle(5, "boot");

        // 0xA5, even parity: popcount 4 -> 0
        frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1, "a5");
        idle(1, "a5");

        // 0x01 odd -> 0, even -> 1
        frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, "o1");
        idle(1, "o1");
        frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, -1, "e1");
        idle(1, "e1");

        // no parity phase; par_bit still latched (1 even)
        frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, -1, "np");
        idle(1, "np");

        // back-to-back with Data_Valid held high
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, "b1");
        frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, -1, "b2");
        idle(2, "b2");

        // 0xFF request during data bit 3 is ignored
        frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3, "ig");
        idle(3, "ig");

        // async reset during data bit 4
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        chk("ar_start", 32'(bus.Mux_sel), 32'h0);
        for (int k = 0; k < 5; k++) tick();
        chk("ar_d4_sel", 32'(bus.Mux_sel), 32'h1);
        #2;
        RST = 1'b0;
        #1;
        chk("ar_sel", 32'(bus.Mux_sel), 32'h3);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_ser", 32'(bus.ser_data), 32'h0);
        chk("ar_par", 32'(bus.par_bit), 32'h0);
        #1;
        RST = 1'b1;
        idle(2, "ar");

        // 0x5A: popcount 4, even -> 0
        frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, -1, "5a");
        idle(2, "5a");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
